// File: rtl/xbar_switch_4x4.sv
// 4x4 store-and-forward crossbar: loads 4 cells per input, then drains 4 routed slots.
// Optional XBAR_RR_PRIORITY_EN selects per-output round-robin arbitration instead of fixed priority.
module xbar_switch_4x4 (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [14:0]       iport0,
   input  logic [14:0]       iport1,
   input  logic [14:0]       iport2,
   input  logic [14:0]       iport3,
   output logic [14:0]       oport0,
   output logic [14:0]       oport1,
   output logic [14:0]       oport2,
   output logic [14:0]       oport3,
   output logic              req,
   output logic              ready
);

   localparam int unsigned CELL_W   = 15;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned NPORT    = 4;
   localparam int unsigned VLD_BIT  = 14;
   localparam int unsigned DEST_LSB = 12;

   localparam logic [1:0] st_idle  = 2'd0;
   localparam logic [1:0] st_load  = 2'd1;
   localparam logic [1:0] st_turn  = 2'd2;
   localparam logic [1:0] st_drain = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [1:0]        cnt, cnt_nxt;
   logic [2:0]        slot, slot_nxt;
   logic              capture;
   logic [1:0]        cap_idx;
   logic              emit;
   logic [1:0]        sidx;

   logic [CELL_W-1:0] cbuf    [NPORT][DEPTH];
   logic [CELL_W-1:0] in_cell [NPORT];
   logic [CELL_W-1:0] route   [NPORT];
   logic [CELL_W-1:0] oreg    [NPORT];

   assign in_cell[0] = iport0;
   assign in_cell[1] = iport1;
   assign in_cell[2] = iport2;
   assign in_cell[3] = iport3;

   assign oport0 = oreg[0];
   assign oport1 = oreg[1];
   assign oport2 = oreg[2];
   assign oport3 = oreg[3];

   assign sidx = slot[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= st_idle;
         cnt   <= '0;
         slot  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         slot  <= slot_nxt;
      end
   end

   // Final drain edge doubles as an idle edge so a new frame can start 9 cycles after the last
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      slot_nxt  = slot;
      capture   = 1'b0;
      cap_idx   = cnt;
      emit      = 1'b0;
      case (state)
         st_idle: begin
            if (start) begin
               capture   = 1'b1;
               cap_idx   = 2'd0;
               cnt_nxt   = 2'd1;
               state_nxt = st_load;
            end
         end
         st_load: begin
            capture = 1'b1;
            cnt_nxt = 2'(cnt + 2'd1);
            if (cnt == 2'd3) state_nxt = st_turn;
         end
         st_turn: begin
            slot_nxt  = '0;
            state_nxt = st_drain;
         end
         st_drain: begin
            if (slot[2]) begin
               slot_nxt  = '0;
               state_nxt = st_idle;
               if (start) begin
                  capture   = 1'b1;
                  cap_idx   = 2'd0;
                  cnt_nxt   = 2'd1;
                  state_nxt = st_load;
               end
            end else begin
               emit     = 1'b1;
               slot_nxt = 3'(slot + 3'd1);
            end
         end
         default: state_nxt = st_idle;
      endcase
   end

`ifdef XBAR_RR_PRIORITY_EN
   logic [1:0] rr_ptr  [NPORT];
   logic [1:0] win_idx [NPORT];
   logic       win_vld [NPORT];

   // Scan from the pointer upward; iterating downward lets the nearest requester win
   always_comb begin
      logic [1:0] cand;
      cand = '0;
      for (int j = 0; j < NPORT; j++) begin
         route[j]   = '0;
         win_vld[j] = 1'b0;
         win_idx[j] = rr_ptr[j];
         for (int k = NPORT - 1; k >= 0; k--) begin
            cand = 2'(rr_ptr[j] + 2'(k));
            if (cbuf[cand][sidx][VLD_BIT] &&
                cbuf[cand][sidx][DEST_LSB +: 2] == 2'(j)) begin
               route[j]   = cbuf[cand][sidx];
               win_vld[j] = 1'b1;
               win_idx[j] = cand;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NPORT; j++) rr_ptr[j] <= '0;
      end else if (emit) begin
         for (int j = 0; j < NPORT; j++)
            if (win_vld[j]) rr_ptr[j] <= 2'(win_idx[j] + 2'd1);
      end
   end
`else
   // Fixed priority: downward scan leaves the lowest-index valid requester
   always_comb begin
      for (int j = 0; j < NPORT; j++) begin
         route[j] = '0;
         for (int i = NPORT - 1; i >= 0; i--) begin
            if (cbuf[i][sidx][VLD_BIT] &&
                cbuf[i][sidx][DEST_LSB +: 2] == 2'(j))
               route[j] = cbuf[i][sidx];
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NPORT; i++) begin
            oreg[i] <= '0;
            for (int d = 0; d < DEPTH; d++) cbuf[i][d] <= '0;
         end
         req   <= 1'b0;
         ready <= 1'b1;
      end else begin
         if (capture)
            for (int i = 0; i < NPORT; i++) cbuf[i][cap_idx] <= in_cell[i];
         for (int j = 0; j < NPORT; j++) oreg[j] <= emit ? route[j] : '0;
         req   <= emit;
         ready <= (state_nxt == st_idle);
      end
   end

endmodule

// File: tb/tb_xbar_switch_4x4.sv
// Directed and randomized frame tests for xbar_switch_4x4 against hand values and a small reference model.
module tb_xbar_switch_4x4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [14:0] iport0, iport1, iport2, iport3;
   logic [14:0] oport0, oport1, oport2, oport3;
   logic        req, ready;

   int total = 0;
   int bad   = 0;

   logic [14:0] cells [4][4];
   logic [14:0] exp_o [4][4];
   logic [1:0]  mptr  [4];

   always #5 clk = ~clk;

   xbar_switch_4x4 dut (
      .clk(clk), .rst(rst), .start(start),
      .iport0(iport0), .iport1(iport1), .iport2(iport2), .iport3(iport3),
      .oport0(oport0), .oport1(oport1), .oport2(oport2), .oport3(oport3),
      .req(req), .ready(ready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, expv);
      end
   endtask

   task automatic drive_slot(input int s);
      iport0 = cells[0][s];
      iport1 = cells[1][s];
      iport2 = cells[2][s];
      iport3 = cells[3][s];
   endtask

   task automatic drive_noise();
      iport0 = 15'($urandom);
      iport1 = 15'($urandom);
      iport2 = 15'($urandom);
      iport3 = 15'($urandom);
   endtask

   function automatic logic [14:0] oport_of(input int j);
      case (j)
         0: return oport0;
         1: return oport1;
         2: return oport2;
         default: return oport3;
      endcase
   endfunction

   // Reference: pick first matching input in priority order, then advance the pointer
   task automatic model_frame();
      for (int s = 0; s < 4; s++) begin
         for (int j = 0; j < 4; j++) begin
            bit found = 0;
            int win = 0;
            exp_o[s][j] = '0;
            for (int k = 0; k < 4; k++) begin
               int i;
               logic [14:0] c;
`ifdef XBAR_RR_PRIORITY_EN
               i = (int'(mptr[j]) + k) % 4;
`else
               i = k;
`endif
               c = cells[i][s];
               if (!found && c[14] && int'(c[13:12]) == j) begin
                  found = 1;
                  win = i;
                  exp_o[s][j] = c;
               end
            end
`ifdef XBAR_RR_PRIORITY_EN
            if (found) mptr[j] = 2'((win + 1) % 4);
`endif
         end
      end
   endtask

   // Edges E0..E3: slot 0 with start, then slots 1-3
   task automatic load_frame(input bit noisy);
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         drive_slot(s);
         if (s == 0)     start = 1'b1;
         else if (noisy) start = 1'($urandom);
         else            start = (s == 2);
         @(posedge clk);
         #1;
         if (s == 0) chk("ready_after_e0", ready, 1'b0);
      end
   endtask

   // Edges E4..E9: turn cycle, four slots, return to idle
   task automatic drain_frame(input bit noisy, input string nm);
      @(negedge clk);
      drive_noise();
      start = noisy ? 1'($urandom) : 1'b0;
      @(posedge clk);
      #1;
      chk({nm, "_req_turn"}, req, 1'b0);
      chk({nm, "_o_turn"}, {oport0, oport1, oport2, oport3}, '0);
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         if (noisy) begin
            drive_noise();
            start = 1'($urandom);
         end
         @(posedge clk);
         #1;
         for (int j = 0; j < 4; j++)
            chk($sformatf("%s_s%0d_o%0d", nm, s, j), oport_of(j), exp_o[s][j]);
         chk($sformatf("%s_s%0d_req", nm, s), req, 1'b1);
         chk($sformatf("%s_s%0d_ready", nm, s), ready, 1'b0);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, "_req_e9"}, req, 1'b0);
      chk({nm, "_ready_e9"}, ready, 1'b1);
      chk({nm, "_o_e9"}, {oport0, oport1, oport2, oport3}, '0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      iport0 = '0; iport1 = '0; iport2 = '0; iport3 = '0;
      for (int j = 0; j < 4; j++) mptr[j] = '0;
      #12;
      chk("rst_o", {oport0, oport1, oport2, oport3}, '0);
      chk("rst_req", req, 1'b0);
      chk("rst_ready", ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Frame A: permutation, reverse, contention, empty
      cells[0][0] = 15'h4001; cells[1][0] = 15'h5002; cells[2][0] = 15'h6003; cells[3][0] = 15'h7004;
      cells[0][1] = 15'h7111; cells[1][1] = 15'h6222; cells[2][1] = 15'h5333; cells[3][1] = 15'h4444;
      cells[0][2] = 15'h6AAA; cells[1][2] = 15'h0000; cells[2][2] = 15'h6BBB; cells[3][2] = 15'h0000;
      cells[0][3] = 15'h0000; cells[1][3] = 15'h2A5A; cells[2][3] = 15'h0000; cells[3][3] = 15'h0000;
      model_frame();
      exp_o[0][0] = 15'h4001; exp_o[0][1] = 15'h5002; exp_o[0][2] = 15'h6003; exp_o[0][3] = 15'h7004;
      exp_o[1][0] = 15'h4444; exp_o[1][1] = 15'h5333; exp_o[1][2] = 15'h6222; exp_o[1][3] = 15'h7111;
      exp_o[2][0] = 15'h0000; exp_o[2][1] = 15'h0000; exp_o[2][3] = 15'h0000;
`ifdef XBAR_RR_PRIORITY_EN
      exp_o[2][2] = 15'h6BBB;
`else
      exp_o[2][2] = 15'h6AAA;
`endif
      exp_o[3][0] = 15'h0000; exp_o[3][1] = 15'h0000; exp_o[3][2] = 15'h0000; exp_o[3][3] = 15'h0000;
      load_frame(1'b0);
      drain_frame(1'b0, "dirA");

      // Async reset in the middle of DRAIN aborts the frame
      @(negedge clk);
      for (int p = 0; p < 4; p++)
         for (int s = 0; s < 4; s++) cells[p][s] = {1'b1, 14'($urandom)};
      load_frame(1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_o", {oport0, oport1, oport2, oport3}, '0);
      chk("midrst_req", req, 1'b0);
      chk("midrst_ready", ready, 1'b1);
      for (int j = 0; j < 4; j++) mptr[j] = '0;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("postrst_c%0d", c), {req, oport0, oport1, oport2, oport3}, '0);
      end
      chk("postrst_ready", ready, 1'b1);

      // Frames B1/B2: contention only, pointers fresh from reset
      for (int p = 0; p < 4; p++)
         for (int s = 0; s < 4; s++) cells[p][s] = '0;
      cells[0][2] = 15'h6AAA;
      cells[2][2] = 15'h6BBB;
      model_frame();
      for (int s = 0; s < 4; s++)
         for (int j = 0; j < 4; j++) exp_o[s][j] = '0;
      exp_o[2][2] = 15'h6AAA;
      load_frame(1'b0);
      drain_frame(1'b0, "contB1");
      model_frame();
`ifdef XBAR_RR_PRIORITY_EN
      exp_o[2][2] = 15'h6BBB;
`else
      exp_o[2][2] = 15'h6AAA;
`endif
      for (int j = 0; j < 4; j++) if (j != 2) exp_o[2][j] = '0;
      load_frame(1'b0);
      drain_frame(1'b0, "contB2");

      // Back-to-back random frames with stray start pulses
      for (int f = 0; f < 256; f++) begin
         for (int p = 0; p < 4; p++)
            for (int s = 0; s < 4; s++) cells[p][s] = 15'($urandom);
         model_frame();
         load_frame(1'b1);
         drain_frame(1'b1, $sformatf("rnd%0d", f));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
